// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// Port ids double as round-robin history values.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } arbState_t;

   localparam logic PORT_CPU = 1'b0;
   localparam logic PORT_DMA = 1'b1;

   localparam int DEFAULT_MEM_BYTES = 256;

   function automatic logic misaligned(input logic [1:0] lsb);
      return lsb != 2'b00;
   endfunction

endpackage

// File: rtl/mem_arbiter_rr.sv
// Two-way round-robin selector.
// grant[0] is the CPU, grant[1] the DMA port.
module rr_arbiter2
   import mem_arb_pkg::*;
(
   input  logic       cReq,
   input  logic       dReq,
   input  logic       lastGrant,
   output logic [1:0] grant
);

   always_comb begin
      grant = 2'b00;
      unique case (1'b1)
         (cReq && !dReq): grant = 2'b01;
         (!cReq && dReq): grant = 2'b10;
         (cReq && dReq):
            grant = (lastGrant == PORT_DMA) ? 2'b01 : 2'b10;
         default: grant = 2'b00;
      endcase
   end

endmodule

// File: rtl/mem_arbiter.sv
// CPU/DMA arbiter in front of a single-port word memory.
// One transaction at a time: IDLE -> (ACCESS) -> RESP -> IDLE.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int MEM_BYTES = DEFAULT_MEM_BYTES,
   parameter int ADDR_W    = 32
) (
   input  logic              CLK,
   input  logic              Reset,
   input  logic              c_req,
   input  logic              c_wr,
   input  logic [ADDR_W-1:0] c_addr,
   input  logic [31:0]       c_wdata,
   output logic              c_ack,
   output logic              c_err,
   input  logic              d_req,
   input  logic              d_wr,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [31:0]       d_wdata,
   output logic              d_ack,
   output logic              d_err,
   output logic [31:0]       rdata,
   output logic [ADDR_W-1:0] m_addr,
   output logic              m_rd,
   output logic              m_wr,
   output logic [31:0]       m_wdata,
   input  logic [31:0]       m_rdata
);

   localparam logic [ADDR_W-1:0] LAST_WORD =
      ADDR_W'(MEM_BYTES - 4);

   arbState_t         state;
   logic              lastGrant;
   logic              curPort;
   logic              curWr;
   logic [ADDR_W-1:0] curAddr;
   logic [31:0]       curWdata;

   logic [1:0]        grant;
   logic              anyReq;
   logic              selPort;
   logic              selWr;
   logic              selErr;
   logic              selCpu;
   logic              selDma;
   logic [ADDR_W-1:0] selAddr;
   logic [31:0]       selWdata;

   rr_arbiter2 uArb (
      .cReq      (c_req),
      .dReq      (d_req),
      .lastGrant (lastGrant),
      .grant     (grant)
   );

   assign anyReq  = |grant;
   assign selPort = grant[1] ? PORT_DMA : PORT_CPU;
   assign selCpu  = (selPort == PORT_CPU);
   assign selDma  = (selPort == PORT_DMA);

   always_comb begin
      selWr    = c_wr;
      selAddr  = c_addr;
      selWdata = c_wdata;
      if (selDma) begin
         selWr    = d_wr;
         selAddr  = d_addr;
         selWdata = d_wdata;
      end
   end

   assign selErr = misaligned(selAddr[1:0])
                || (selAddr > LAST_WORD);

   assign m_addr  = curAddr;
   assign m_wdata = curWdata;

   // Grant latches the request; later input changes are ignored.
   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         state     <= IDLE;
         lastGrant <= PORT_DMA;
         curPort   <= PORT_CPU;
         curWr     <= 1'b0;
         curAddr   <= '0;
         curWdata  <= '0;
         m_rd      <= 1'b0;
         m_wr      <= 1'b0;
         rdata     <= '0;
         c_ack     <= 1'b0;
         c_err     <= 1'b0;
         d_ack     <= 1'b0;
         d_err     <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (anyReq) begin
                  lastGrant <= selPort;
                  curPort   <= selPort;
                  curWr     <= selWr;
                  curAddr   <= selAddr;
                  curWdata  <= selWdata;
                  if (selErr) begin
                     state <= RESP;
                     c_ack <= selCpu;
                     c_err <= selCpu;
                     d_ack <= selDma;
                     d_err <= selDma;
                  end else begin
                     state <= ACCESS;
                     m_rd  <= !selWr;
                     m_wr  <= selWr;
                  end
               end
            end
            ACCESS: begin
               state <= RESP;
               m_rd  <= 1'b0;
               m_wr  <= 1'b0;
               if (m_rd)
                  rdata <= m_rdata;
               c_ack <= (curPort == PORT_CPU);
               d_ack <= (curPort == PORT_DMA);
            end
            RESP: begin
               state <= IDLE;
               c_ack <= 1'b0;
               c_err <= 1'b0;
               d_ack <= 1'b0;
               d_err <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table, corner
// sequences and a transaction-level random reference model.
module tb_mem_arbiter;

   localparam int MB = 256;
   localparam int AW = 32;
   localparam logic [31:0] LASTW = 32'(MB - 4);

   logic CLK;
   logic Reset;
   logic c_req, c_wr, c_ack, c_err;
   logic d_req, d_wr, d_ack, d_err;
   logic [AW-1:0] c_addr, d_addr, m_addr;
   logic [31:0] c_wdata, d_wdata;
   logic [31:0] rdata, m_wdata, m_rdata;
   logic m_rd, m_wr;

   logic        reqV  [2];
   logic        wrV   [2];
   logic [31:0] addrV [2];
   logic [31:0] dataV [2];

   assign c_req   = reqV[0];
   assign c_wr    = wrV[0];
   assign c_addr  = addrV[0];
   assign c_wdata = dataV[0];
   assign d_req   = reqV[1];
   assign d_wr    = wrV[1];
   assign d_addr  = addrV[1];
   assign d_wdata = dataV[1];

   logic [7:0] mem    [MB];
   logic [7:0] refMem [MB];
   bit         memInit;

   int nCmp = 0;
   int nBad = 0;

   mem_arbiter #(.MEM_BYTES(MB), .ADDR_W(AW)) dut (
      .CLK     (CLK),
      .Reset   (Reset),
      .c_req   (c_req),
      .c_wr    (c_wr),
      .c_addr  (c_addr),
      .c_wdata (c_wdata),
      .c_ack   (c_ack),
      .c_err   (c_err),
      .d_req   (d_req),
      .d_wr    (d_wr),
      .d_addr  (d_addr),
      .d_wdata (d_wdata),
      .d_ack   (d_ack),
      .d_err   (d_err),
      .rdata   (rdata),
      .m_addr  (m_addr),
      .m_rd    (m_rd),
      .m_wr    (m_wr),
      .m_wdata (m_wdata),
      .m_rdata (m_rdata)
   );

   always begin
      CLK = 1'b0; #5;
      CLK = 1'b1; #5;
   end

   function automatic logic [7:0] pat(input int i);
      return 8'((i * 37 + 11) % 256);
   endfunction

   // External memory: big-endian word read, write on falling edge.
   always_comb begin
      m_rdata = '0;
      if (m_addr <= LASTW)
         m_rdata = {mem[m_addr[7:0]], mem[m_addr[7:0] + 8'd1],
                    mem[m_addr[7:0] + 8'd2], mem[m_addr[7:0] + 8'd3]};
   end

   always @(negedge CLK) begin
      if (!memInit) begin
         for (int i = 0; i < MB; i++) mem[i] <= pat(i);
         memInit <= 1'b1;
      end else if (m_wr && m_addr <= LASTW) begin
         mem[m_addr[7:0]]         <= m_wdata[31:24];
         mem[m_addr[7:0] + 8'd1]  <= m_wdata[23:16];
         mem[m_addr[7:0] + 8'd2]  <= m_wdata[15:8];
         mem[m_addr[7:0] + 8'd3]  <= m_wdata[7:0];
      end
   end

   function automatic logic [31:0] refWord(input logic [31:0] a);
      int i;
      i = int'(a[7:0]);
      return {refMem[i], refMem[i+1], refMem[i+2], refMem[i+3]};
   endfunction

   function automatic logic [31:0] memWord(input logic [31:0] a);
      int i;
      i = int'(a[7:0]);
      return {mem[i], mem[i+1], mem[i+2], mem[i+3]};
   endfunction

   task automatic refWrite(input logic [31:0] a, input logic [31:0] w);
      int i;
      i = int'(a[7:0]);
      refMem[i]   = w[31:24];
      refMem[i+1] = w[23:16];
      refMem[i+2] = w[15:8];
      refMem[i+3] = w[7:0];
   endtask

   function automatic logic badAddr(input logic [31:0] a);
      return (a % 4 != 0) || (a > LASTW);
   endfunction

   function automatic logic [31:0] randAddr();
      logic [31:0] a;
      case ($urandom_range(0, 9))
         0, 1, 2, 3, 4, 5: a = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
         6: a = {24'd0, 8'($urandom_range(0, 255))} | 32'h1;
         7: a = 32'($urandom_range(253, 300));
         8: a = 32'hFC;
         default: a = $urandom;
      endcase
      return a;
   endfunction

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      nCmp++;
      if (act !== exp) begin
         nBad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic doTxn(input int tag, input int p, input logic wr,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic expErr, input logic [31:0] expRd);
      int n, nWr, nRd, nOther;
      logic got, err;
      logic [31:0] rd;
      n = 0; nWr = 0; nRd = 0; nOther = 0;
      got = 1'b0; err = 1'b0; rd = '0;
      tick();
      reqV[p] = 1'b1; wrV[p] = wr; addrV[p] = addr; dataV[p] = wdata;
      while (!got && n < 8) begin
         tick();
         n++;
         nWr += int'(m_wr);
         nRd += int'(m_rd);
         if (p == 0 ? d_ack : c_ack) nOther++;
         if (p == 0 ? c_ack : d_ack) begin
            got = 1'b1;
            err = (p == 0) ? c_err : d_err;
            rd  = rdata;
         end
      end
      reqV[p] = 1'b0;
      check($sformatf("t%0d.ack", tag), 32'(got), 32'd1);
      check($sformatf("t%0d.latency", tag), n, expErr ? 1 : 2);
      check($sformatf("t%0d.err", tag), 32'(err), 32'(expErr));
      check($sformatf("t%0d.m_wr", tag), nWr, (wr && !expErr) ? 1 : 0);
      check($sformatf("t%0d.m_rd", tag), nRd, (!wr && !expErr) ? 1 : 0);
      check($sformatf("t%0d.otherAck", tag), nOther, 0);
      if (!wr && !expErr)
         check($sformatf("t%0d.rdata", tag), rd, expRd);
      if (wr && !expErr) refWrite(addr, wdata);
   endtask

   typedef struct {
      int          port;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        expErr;
      logic [31:0] expRd;
   } vec_t;

   vec_t vecs [11];

   // Transaction-level reference state for the random phase
   int   edgeN, idleEdge, ackEdge, accEdge;
   logic lastG, win, ackPort, ackErr, ackRd, accWr;
   logic [31:0] ackData, accAddr, accData, expRd, gAddr, gData;
   logic gWr;
   int   rqSt [2];

   initial begin
      int cAt, dAt, nSim, nAck, cyc0;
      logic got;
      string order;

      for (int i = 0; i < MB; i++) refMem[i] = pat(i);
      for (int p = 0; p < 2; p++) begin
         reqV[p] = 1'b0; wrV[p] = 1'b0; addrV[p] = '0; dataV[p] = '0;
      end
      Reset = 1'b1;
      #2 Reset = 1'b0;
      tick(); tick();
      check("reset.c_ack", 32'(c_ack), 0);
      check("reset.d_ack", 32'(d_ack), 0);
      check("reset.errs", 32'({c_err, d_err}), 0);
      check("reset.rdata", rdata, 0);
      check("reset.m_addr", m_addr, 0);
      check("reset.m_rdwr", 32'({m_rd, m_wr}), 0);
      check("reset.m_wdata", m_wdata, 0);
      Reset = 1'b1;

      vecs[0]  = '{0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0};
      vecs[1]  = '{0, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF};
      vecs[2]  = '{0, 1'b0, 32'h12, 32'h0, 1'b1, 32'h0};
      vecs[3]  = '{1, 1'b0, 32'hFD, 32'h0, 1'b1, 32'h0};
      vecs[4]  = '{1, 1'b1, 32'hFC, 32'h0BADF00D, 1'b0, 32'h0};
      vecs[5]  = '{1, 1'b0, 32'hFC, 32'h0, 1'b0, 32'h0BADF00D};
      vecs[6]  = '{0, 1'b0, 32'h100, 32'h0, 1'b1, 32'h0};
      vecs[7]  = '{1, 1'b1, 32'h0, 32'h12345678, 1'b0, 32'h0};
      vecs[8]  = '{0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h12345678};
      vecs[9]  = '{0, 1'b1, 32'hFFFFFFFC, 32'h55AA55AA, 1'b1, 32'h0};
      vecs[10] = '{1, 1'b1, 32'hFE, 32'h77777777, 1'b1, 32'h0};
      for (int v = 0; v < 11; v++)
         doTxn(v, vecs[v].port, vecs[v].wr, vecs[v].addr,
               vecs[v].wdata, vecs[v].expErr, vecs[v].expRd);
      check("bigEndian.mem10", 32'(mem[16]), 32'hDE);
      check("bigEndian.mem13", 32'(mem[19]), 32'hEF);

      // DMA drops req and changes addr right after its grant
      doTxn(20, 0, 1'b1, 32'h30, 32'h11112222, 1'b0, 32'h0);
      doTxn(21, 0, 1'b1, 32'h40, 32'h33334444, 1'b0, 32'h0);
      tick();
      reqV[1] = 1'b1; wrV[1] = 1'b0; addrV[1] = 32'h30;
      tick();
      check("drop.m_rd", 32'(m_rd), 1);
      check("drop.m_addr", m_addr, 32'h30);
      reqV[1] = 1'b0; addrV[1] = 32'h40; wrV[1] = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 5 && !got; i++) begin
         tick();
         check("drop.m_wr", 32'(m_wr), 0);
         if (d_ack) begin
            got = 1'b1;
            check("drop.rdata", rdata, 32'h11112222);
            check("drop.d_err", 32'(d_err), 0);
         end
      end
      check("drop.ack", 32'(got), 1);

      // Reset during the ACCESS cycle of a write
      tick();
      reqV[0] = 1'b1; wrV[0] = 1'b1; addrV[0] = 32'h20;
      dataV[0] = 32'hCAFEF00D;
      tick();
      check("rst.m_wr_pre", 32'(m_wr), 1);
      Reset = 1'b0;
      #1;
      check("rst.m_wr", 32'(m_wr), 0);
      check("rst.m_rd", 32'(m_rd), 0);
      check("rst.rdata", rdata, 0);
      reqV[0] = 1'b0;
      tick(); tick();
      Reset = 1'b1;
      nAck = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         nAck += int'(c_ack) + int'(d_ack);
      end
      check("rst.noAck", nAck, 0);
      check("rst.memKept", memWord(32'h20), refWord(32'h20));
      doTxn(30, 0, 1'b0, 32'h20, 32'h0, 1'b0, refWord(32'h20));

      // Both request from reset: CPU first, DMA three cycles later
      tick();
      Reset = 1'b0;
      reqV[0] = 1'b1; wrV[0] = 1'b0; addrV[0] = 32'h10;
      reqV[1] = 1'b1; wrV[1] = 1'b0; addrV[1] = 32'h14;
      tick(); tick();
      Reset = 1'b1;
      cAt = -1; dAt = -1; nSim = 0;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (c_ack && d_ack) nSim++;
         if (c_ack && cAt < 0) begin
            cAt = i; reqV[0] = 1'b0;
            check("tie.c_rdata", rdata, 32'hDEADBEEF);
         end
         if (d_ack && dAt < 0) begin
            dAt = i; reqV[1] = 1'b0;
            check("tie.d_rdata", rdata, refWord(32'h14));
         end
      end
      check("tie.cAt", cAt, 2);
      check("tie.gap", dAt - cAt, 3);
      check("tie.simul", nSim, 0);

      // Continuous requests alternate grants
      tick();
      reqV[0] = 1'b1; addrV[0] = 32'h10;
      reqV[1] = 1'b1; addrV[1] = 32'h14;
      order = ""; nSim = 0;
      for (int i = 0; i < 40 && order.len() < 6; i++) begin
         tick();
         if (c_ack && d_ack) nSim++;
         if (c_ack) order = {order, "C"};
         if (d_ack) order = {order, "D"};
      end
      reqV[0] = 1'b0; reqV[1] = 1'b0;
      nCmp++;
      if (order != "CDCDCD") begin
         nBad++;
         $display("FAIL rr.order: got %s want CDCDCD", order);
      end
      check("rr.simul", nSim, 0);

      // Randomized traffic against the transaction-level model
      tick();
      Reset = 1'b0;
      tick(); tick();
      Reset = 1'b1;
      edgeN = 0; idleEdge = 0; ackEdge = -1; accEdge = -1;
      lastG = 1'b1; expRd = '0;
      ackPort = 1'b0; ackErr = 1'b0; ackRd = 1'b0; ackData = '0;
      accWr = 1'b0; accAddr = '0; accData = '0;
      rqSt[0] = 0; rqSt[1] = 0;
      for (int cyc = 0; cyc < 1500; cyc++) begin
         @(posedge CLK);
         edgeN++;
         if (edgeN >= idleEdge && (reqV[0] || reqV[1])) begin
            win   = (reqV[0] && reqV[1]) ? !lastG : reqV[1];
            lastG = win;
            gWr   = wrV[int'(win)];
            gAddr = addrV[int'(win)];
            gData = dataV[int'(win)];
            ackPort = win;
            ackErr  = badAddr(gAddr);
            ackRd   = !gWr;
            ackEdge  = edgeN + (ackErr ? 0 : 1);
            idleEdge = edgeN + (ackErr ? 2 : 3);
            if (!ackErr) begin
               accEdge = edgeN; accWr = gWr;
               accAddr = gAddr; accData = gData;
               if (gWr) refWrite(gAddr, gData);
               else ackData = refWord(gAddr);
            end
            rqSt[int'(win)] = 2;
         end
         #1;
         check("rnd.c_ack", 32'(c_ack), 32'(ackEdge == edgeN && !ackPort));
         check("rnd.d_ack", 32'(d_ack), 32'(ackEdge == edgeN && ackPort));
         check("rnd.c_err", 32'(c_err),
               32'(ackEdge == edgeN && !ackPort && ackErr));
         check("rnd.d_err", 32'(d_err),
               32'(ackEdge == edgeN && ackPort && ackErr));
         if (ackEdge == edgeN && !ackErr && ackRd) expRd = ackData;
         check("rnd.rdata", rdata, expRd);
         check("rnd.m_wr", 32'(m_wr), 32'(accEdge == edgeN && accWr));
         check("rnd.m_rd", 32'(m_rd), 32'(accEdge == edgeN && !accWr));
         if (accEdge == edgeN) begin
            check("rnd.m_addr", m_addr, accAddr);
            if (accWr) check("rnd.m_wdata", m_wdata, accData);
         end
         for (int p = 0; p < 2; p++) begin
            if (rqSt[p] == 2 && ackEdge == edgeN && int'(ackPort) == p) begin
               rqSt[p] = 0;
               reqV[p] = 1'b0;
            end else if (rqSt[p] == 2) begin
               if ($urandom_range(0, 3) == 0) begin
                  wrV[p] = 1'($urandom_range(0, 1));
                  addrV[p] = $urandom;
                  dataV[p] = $urandom;
               end
               if ($urandom_range(0, 7) == 0) reqV[p] = 1'b0;
            end
            if (rqSt[p] == 0 && cyc < 1480 && $urandom_range(0, 2) == 0) begin
               rqSt[p]  = 1;
               reqV[p]  = 1'b1;
               wrV[p]   = 1'($urandom_range(0, 1));
               addrV[p] = randAddr();
               dataV[p] = $urandom;
            end
         end
      end
      cyc0 = edgeN;
      check("rnd.progress", 32'(cyc0 > 1000), 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
      $finish;
   end

endmodule
